seq_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU for the multicycle MIPS core.
- Adds XOR/NOR/signed and unsigned compare/shift ops, plus iterative unsigned multiply and divide.
- Uses a start/busy/done handshake so the multicycle control FSM can stall on long operations.
- Sits between the A/B operand registers and ALUOut/HI/LO.

---
 rtl/seq_alu_if.sv | 41 ++++
 rtl/seq_alu.sv | 249 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done operand and result bundle for seq_alu.
// The Overflow signal exists only when SEQ_ALU_OVERFLOW_EN is defined.
//
// Handshake: the master raises start for one cycle with operand1, operand2
// and ALUControl valid. The request is taken only when the ALU is neither
// busy nor mid-iteration (IDLE or DONE state). A start seen while busy=1 is
// dropped, not queued. done pulses for exactly one cycle when ALUResult,
// ALUHi and div_by_zero are valid. busy and done are never high together.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       ALUControl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUHi;
  logic             Zero;
  logic             div_by_zero;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic             Overflow;
`endif

  modport master (
    output start, operand1, operand2, ALUControl,
    input  busy, done, ALUResult, ALUHi, Zero, div_by_zero
`ifdef SEQ_ALU_OVERFLOW_EN
    , input Overflow
`endif
  );

  modport slave (
    input  start, operand1, operand2, ALUControl,
    output busy, done, ALUResult, ALUHi, Zero, div_by_zero
`ifdef SEQ_ALU_OVERFLOW_EN
    , output Overflow
`endif
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU for the multicycle MIPS core.
// Single-cycle ops complete one cycle after start; MULTU (shift-add) and
// DIVU (restoring) iterate WIDTH cycles in MUL/DIV and complete on the
// following cycle. Results hold until the next accepted operation completes.
// Optional feature macro: SEQ_ALU_OVERFLOW_EN adds the registered Overflow
// output for signed ADD/SUB.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Iteration registers shared by MUL and DIV.
  // MUL: work_hi = upper product half, work_lo = multiplier shifting out
  //      while low product bits shift in, opnd = multiplicand.
  // DIV: work_hi = partial remainder, work_lo = dividend shifting out while
  //      quotient bits shift in, opnd = divisor.
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Visible result registers.
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;

  // Single-cycle datapath.
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;

  // Iteration datapath.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  logic accept;

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic alu_ovf;
`endif

  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // Single-cycle operation results from the live operand inputs.
  always_comb begin
    add_res = bus.operand1 + bus.operand2;
    sub_res = bus.operand1 - bus.operand2;
    shamt   = bus.operand2[SHW-1:0];
    alu_out = '0;
    case (bus.ALUControl)
      OP_AND:  alu_out = bus.operand1 & bus.operand2;
      OP_OR:   alu_out = bus.operand1 | bus.operand2;
      OP_ADD:  alu_out = add_res;
      OP_XOR:  alu_out = bus.operand1 ^ bus.operand2;
      OP_NOR:  alu_out = ~(bus.operand1 | bus.operand2);
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (bus.operand1 < bus.operand2)};
      OP_SUB:  alu_out = sub_res;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}},
                          ($signed(bus.operand1) < $signed(bus.operand2))};
      OP_SLL:  alu_out = bus.operand1 << shamt;
      OP_SRL:  alu_out = bus.operand1 >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(bus.operand1) >>> shamt);
      default: alu_out = '0;
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  // Signed overflow: ADD with like-signed operands, SUB with unlike-signed
  // operands, where the result sign disagrees with operand1.
  always_comb begin
    alu_ovf = 1'b0;
    case (bus.ALUControl)
      OP_ADD: alu_ovf = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                        (add_res[WIDTH-1] != bus.operand1[WIDTH-1]);
      OP_SUB: alu_ovf = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                        (sub_res[WIDTH-1] != bus.operand1[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  // Next-state and next-register logic for the operation FSM.
  always_comb begin
    state_d   = state_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    hi_d      = hi_q;
    dbz_d     = dbz_q;
`ifdef SEQ_ALU_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          dbz_d = 1'b0;
          case (bus.ALUControl)
            OP_MULTU: begin
              opnd_d    = bus.operand1;
              work_hi_d = '0;
              work_lo_d = bus.operand2;
              cnt_d     = CW'(WIDTH);
              state_d   = S_MUL;
            end
            OP_DIVU: begin
              if (bus.operand2 == '0) begin
                result_d = '1;
                hi_d     = bus.operand1;
                dbz_d    = 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
                ovf_d    = 1'b0;
`endif
                state_d  = S_DONE;
              end else begin
                opnd_d    = bus.operand2;
                work_hi_d = '0;
                work_lo_d = bus.operand1;
                cnt_d     = CW'(WIDTH);
                state_d   = S_DIV;
              end
            end
            default: begin
              result_d = alu_out;
              hi_d     = '0;
`ifdef SEQ_ALU_OVERFLOW_EN
              ovf_d    = alu_ovf;
`endif
              state_d  = S_DONE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        work_hi_d = mul_sum[WIDTH:1];
        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
          hi_d     = mul_sum[WIDTH:1];
`ifdef SEQ_ALU_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        work_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = {work_lo_q[WIDTH-2:0], div_ge};
          hi_d     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
`ifdef SEQ_ALU_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides any in-flight iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      dbz_q     <= dbz_d;
`ifdef SEQ_ALU_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done        = (state_q == S_DONE);
  assign bus.ALUResult   = result_q;
  assign bus.ALUHi       = hi_q;
  assign bus.Zero        = (result_q == '0);
  assign bus.div_by_zero = dbz_q;
`ifdef SEQ_ALU_OVERFLOW_EN
  assign bus.Overflow    = ovf_q;
`endif
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed, table-driven bench for seq_alu at WIDTH=32, with
// hand-written sequences for busy-ignore, mid-iteration reset, back-to-back
// operation and (when SEQ_ALU_OVERFLOW_EN is defined) Overflow.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic [W-1:0] exp_hi;
    logic         exp_dbz;
    int           exp_lat;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: one start pulse, then wait (bounded) for done, sampling on negedge.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt, output bit overlap);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.operand1   = a;
    bus.operand2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat     = 1;
    bcnt    = 0;
    overlap = 1'b0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    overlap = bus.busy && bus.done;
  endtask

  vec_t vecs[$];

  initial begin
    int  lat;
    int  bcnt;
    bit  overlap;
    n_checks = 0;
    n_fail   = 0;
    bus.start      = 1'b0;
    bus.ALUControl = 4'b0;
    bus.operand1   = '0;
    bus.operand2   = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_res",   bus.ALUResult, 0);
    check("rst_hi",    bus.ALUHi, 0);
    check("rst_zero",  bus.Zero, 1);
    check("rst_dbz",   bus.div_by_zero, 0);
    check("rst_state", dbg_state, 0);
`ifdef SEQ_ALU_OVERFLOW_EN
    check("rst_ovf",   bus.Overflow, 0);
`endif
    reset = 1'b0;

    // Vector table.
    vecs.push_back('{"add",      OP_ADD,   32'h7,        32'h5,        32'hC,        32'h0, 1'b0, 1});
    vecs.push_back('{"sub_zero", OP_SUB,   32'h5,        32'h5,        32'h0,        32'h0, 1'b0, 1});
    vecs.push_back('{"slt",      OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        32'h0, 1'b0, 1});
    vecs.push_back('{"sltu",     OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1'b0, 1});
    vecs.push_back('{"sra",      OP_SRA,   32'h80000000, 32'h4,        32'hF8000000, 32'h0, 1'b0, 1});
    vecs.push_back('{"srl",      OP_SRL,   32'h80000000, 32'h4,        32'h08000000, 32'h0, 1'b0, 1});
    vecs.push_back('{"sll31",    OP_SLL,   32'h1,        32'd31,       32'h80000000, 32'h0, 1'b0, 1});
    vecs.push_back('{"sll_mask", OP_SLL,   32'h1,        32'h21,       32'h2,        32'h0, 1'b0, 1});
    vecs.push_back('{"and",      OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1});
    vecs.push_back('{"or",       OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1});
    vecs.push_back('{"xor",      OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1});
    vecs.push_back('{"nor",      OP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 1'b0, 1});
    vecs.push_back('{"add_wrap", OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1'b0, 1});
    vecs.push_back('{"sub_wrap", OP_SUB,   32'h0,        32'h1,        32'hFFFFFFFF, 32'h0, 1'b0, 1});
    vecs.push_back('{"op_1011",  4'b1011,  32'h12345678, 32'h9,        32'h0,        32'h0, 1'b0, 1});
    vecs.push_back('{"multu",    OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1, 1'b0, 33});
    vecs.push_back('{"op_1111",  4'b1111,  32'hAAAA5555, 32'h3,        32'h0,        32'h0, 1'b0, 1});
    vecs.push_back('{"multu_2",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h0,        32'h1, 1'b0, 33});
    vecs.push_back('{"multu_3",  OP_MULTU, 32'd1000,     32'd3000,     32'd3000000,  32'h0, 1'b0, 33});
    vecs.push_back('{"divu",     OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 33});
    vecs.push_back('{"divu_dz",  OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b1, 1});
    vecs.push_back('{"add_clr",  OP_ADD,   32'd2,        32'd3,        32'd5,        32'h0, 1'b0, 1});
    vecs.push_back('{"divu_big", OP_DIVU,  32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'h0, 1'b0, 33});
    vecs.push_back('{"divu_lt",  OP_DIVU,  32'd5,        32'd9,        32'd0,        32'd5, 1'b0, 33});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, overlap);
      check({vecs[i].name, "_lat"},  lat, vecs[i].exp_lat);
      check({vecs[i].name, "_busy"}, bcnt, vecs[i].exp_lat - 1);
      check({vecs[i].name, "_excl"}, overlap, 0);
      check({vecs[i].name, "_res"},  bus.ALUResult, vecs[i].exp_res);
      check({vecs[i].name, "_hi"},   bus.ALUHi, vecs[i].exp_hi);
      check({vecs[i].name, "_zero"}, bus.Zero, (vecs[i].exp_res == '0));
      check({vecs[i].name, "_dbz"},  bus.div_by_zero, vecs[i].exp_dbz);
      @(negedge clk);
      check({vecs[i].name, "_done1"}, bus.done, 0);
    end

    // Starts pulsed while busy are dropped: result and latency unchanged.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = OP_MULTU;
    bus.operand1   = 32'hFFFFFFFF;
    bus.operand2   = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 4 || lat == 20) begin
        bus.start      = 1'b1;
        bus.ALUControl = OP_ADD;
        bus.operand1   = 32'h1;
        bus.operand2   = 32'h1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("ign_lat", lat, 33);
    check("ign_res", bus.ALUResult, 32'hFFFFFFFE);
    check("ign_hi",  bus.ALUHi, 32'h1);
    @(negedge clk);
    check("ign_noq_done",  bus.done, 0);
    check("ign_noq_state", dbg_state, 0);

    // Reset at iteration 10 of MULTU, after a nonzero result is on the outputs.
    run_op(OP_ADD, 32'h7, 32'h5, lat, bcnt, overlap);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = OP_MULTU;
    bus.operand1   = 32'h1234;
    bus.operand2   = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_pre", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy", bus.busy, 0);
    check("mid_done", bus.done, 0);
    check("mid_res",  bus.ALUResult, 0);
    check("mid_hi",   bus.ALUHi, 0);
    check("mid_zero", bus.Zero, 1);
    run_op(OP_ADD, 32'd2, 32'd3, lat, bcnt, overlap);
    check("post_rst_lat", lat, 1);
    check("post_rst_res", bus.ALUResult, 32'd5);

    // Back-to-back: start held high across DONE, ADD then OR.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = OP_ADD;
    bus.operand1   = 32'd10;
    bus.operand2   = 32'd20;
    @(negedge clk);
    check("b2b_done1", bus.done, 1);
    check("b2b_res1",  bus.ALUResult, 32'd30);
    bus.ALUControl = OP_OR;
    bus.operand1   = 32'hF0;
    bus.operand2   = 32'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done2", bus.done, 1);
    check("b2b_res2",  bus.ALUResult, 32'hFF);
    @(negedge clk);
    check("b2b_done3", bus.done, 0);
    check("b2b_hold",  bus.ALUResult, 32'hFF);

`ifdef SEQ_ALU_OVERFLOW_EN
    run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat, bcnt, overlap);
    check("ovf_add",     bus.Overflow, 1);
    check("ovf_add_res", bus.ALUResult, 32'h80000000);
    run_op(OP_SUB, 32'h80000000, 32'h1, lat, bcnt, overlap);
    check("ovf_sub",     bus.Overflow, 1);
    check("ovf_sub_res", bus.ALUResult, 32'h7FFFFFFF);
    run_op(OP_ADD, 32'hFFFFFFFF, 32'h1, lat, bcnt, overlap);
    check("ovf_none",    bus.Overflow, 0);
    run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat, bcnt, overlap);
    run_op(OP_MULTU, 32'h2, 32'h3, lat, bcnt, overlap);
    check("ovf_mul_clr", bus.Overflow, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
